seq_detect_fsm: RTL and testbench
=================================

// Module: seq_detect_fsm
// PURPOSE
//  Parametrised serial pattern detector; successor to the fixed 4-state control FSMs in this codebase.
//  Accepts one bit per cycle under a valid qualifier and pulses 'match' when the last LEN accepted bits
//  equal PATTERN. Overlapping and non-overlapping detection are selectable. Keeps a saturating match count.
//  Sits between a serial input stage and downstream control logic that consumes match events.
// PARAMETERS
//  LEN      4        pattern length in bits, 2..32
//  PATTERN  4'b1011  pattern; PATTERN[LEN-1] is the first bit received, PATTERN[0] the last
//  OVERLAP  1        1: a match's bits may start the next match; 0: history is discarded after a match
//  CNT_W    8        width of match_cnt, 1..32
// PORTS
//  clk        in   1                 rising-edge clock
//  rst_n      in   1                 asynchronous active-low reset
//  clr        in   1                 synchronous clear of history, fill, match, match_cnt
//  in_valid   in   1                 in_bit is accepted on this edge when high
//  in_bit     in   1                 serial data bit
//  match      out  1                 registered one-cycle pulse: pattern completed by the bit just accepted
//  match_cnt  out  CNT_W             number of matches since reset/clr, saturating
//  fill       out  $clog2(LEN+1)     accepted bits currently in history, 0..LEN
// BEHAVIOUR
//  - Reset (rst_n=0, async, no clock needed): hist=0, fill=0, match=0, match_cnt=0.
//  - State: hist[LEN-1:0] shift register, fill counter, match flag, match_cnt.
//  - FSM view (fill): EMPTY (0) -> FILLING (1..LEN-1) -> FULL (LEN). FULL is left only via a
//    non-overlap match, clr or reset.
//  - Priority per edge: rst_n > clr > in_valid > hold.
//  - clr=1: hist=0, fill=0, match=0, match_cnt=0. in_valid is ignored in the same cycle.
//  - in_valid=1, clr=0:
//    - h' = {hist[LEN-2:0], in_bit}.
//    - f' = min(fill+1, LEN).
//    - hit = (f' == LEN) && (h' == PATTERN).
//    - match <= hit.
//    - match_cnt <= match_cnt+1 on hit, unless it is already all-ones (saturates, no wrap).
//    - OVERLAP=1: hist <= h', fill <= f'.
//    - OVERLAP=0 and hit: hist <= 0, fill <= 0.
//    - OVERLAP=0 and no hit: hist <= h', fill <= f'.
//  - in_valid=0, clr=0: hist, fill and match_cnt hold; match <= 0.
//  - Latency: match is high during the cycle after the edge that accepts the completing bit.
//    match_cnt updates on that same edge.
//  - Back-to-back: with OVERLAP=1 and a self-overlapping pattern, match may be high on consecutive cycles.
//  - Bits before a full window never match: a prefix shorter than LEN gives match=0, even if the stale
//    hist equals PATTERN.
//  - Reset or clr mid-pattern discards partial history; detection restarts from fill=0.
//  - Outputs are driven only by registers; there are no combinational paths from inputs to outputs.
// TESTING
//  1. Reset: assert rst_n=0 asynchronously between edges -> match=0, match_cnt=0, fill=0 immediately.
//  2. Overlap (LEN=4, PATTERN=1011, OVERLAP=1): send 1,0,1,1,0,1,1 with in_valid=1
//     -> match after bits 4 and 7; match_cnt=2; fill=4.
//  3. Non-overlap (OVERLAP=0): same stream -> match after bit 4 only; match_cnt=1; fill=3 at the end.
//  4. Valid gaps: send 1,0 / idle 3 cycles / 1,1 -> one match, after the last bit; match=0 during idle.
//  5. Saturation (CNT_W=2, OVERLAP=1, PATTERN=1111): send 7 consecutive 1s
//     -> match high for 4 consecutive cycles; match_cnt stops at 3.
//  6. clr priority: send 1,0,1, then clr=1 with in_valid=1, in_bit=1 in the same cycle, then 1,0,1,1
//     -> no match at the clr cycle; fill=0 after clr; one match after the final 1.

Source files
------------

// File: rtl/seq_detect_if.sv
// Serial detector bus: bit stream in, match events, running count and fill out.
// master drives in_valid/in_bit; slave (the detector) drives match/match_cnt/fill.
interface seq_detect_if #(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
);
    localparam int FW = $clog2(LEN + 1);

    logic             in_valid;
    logic             in_bit;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic [FW-1:0]    fill;

    modport master (
        output in_valid,
        output in_bit,
        input  match,
        input  match_cnt,
        input  fill
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        output match,
        output match_cnt,
        output fill
    );
endinterface

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: pulses match when the last LEN accepted bits equal PATTERN.
// Ports: clk, rst_n (async low), clr (sync clear), bus (in_valid/in_bit in; match/match_cnt/fill out).
module seq_detect_fsm #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    seq_detect_if.slave bus
);
    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL_CNT = FW'(LEN);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN-1:0]   hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [LEN-1:0]   h_nxt;
    logic [FW-1:0]    f_nxt;
    logic             hit;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        h_nxt = {hist_q[LEN-2:0], bus.in_bit};
        // Once full, the window just slides; fill stays pinned at LEN.
        f_nxt = (state_q == FULL) ? FULL_CNT : fill_q + 1'b1;
        hit   = (f_nxt == FULL_CNT) && (h_nxt == PATTERN);

        if (clr) begin
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            state_d = EMPTY;
        end else if (bus.in_valid) begin
            match_d = hit;
            if (hit && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (hit && !OVERLAP) begin
                hist_d  = '0;
                fill_d  = '0;
                state_d = EMPTY;
            end else begin
                hist_d  = h_nxt;
                fill_d  = f_nxt;
                state_d = (f_nxt == FULL_CNT) ? FULL : FILLING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.fill      = fill_q;
endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: three configurations share one stimulus stream.
// A: 1011 overlap, B: 1011 non-overlap, C: 1111 overlap with a 2-bit counter.
module tb_seq_detect_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr = 1'b0;
    logic v = 1'b0;
    logic b = 1'b0;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    seq_detect_if #(.LEN(4), .CNT_W(8)) ia ();
    seq_detect_if #(.LEN(4), .CNT_W(8)) ib ();
    seq_detect_if #(.LEN(4), .CNT_W(2)) ic ();

    assign ia.in_valid = v;
    assign ia.in_bit   = b;
    assign ib.in_valid = v;
    assign ib.in_bit   = b;
    assign ic.in_valid = v;
    assign ic.in_bit   = b;

    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
        u_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ia));
    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
        u_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ib));
    seq_detect_fsm #(.LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2))
        u_c (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ic));

    // Model: list of the most recent accepted bits, oldest first.
    int pat[3]  = '{11, 11, 15};
    bit ovl[3]  = '{1'b1, 1'b0, 1'b1};
    int cmax[3] = '{255, 255, 3};
    bit rb[3][4];
    int mn[3];
    int mcnt[3];
    bit mmatch[3];

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            mn[i] = 0;
            mcnt[i] = 0;
            mmatch[i] = 1'b0;
            for (int k = 0; k < 4; k++) rb[i][k] = 1'b0;
        end
    endtask

    task automatic model_accept(input bit nb);
        for (int i = 0; i < 3; i++) begin
            bit eq;
            if (mn[i] == 4) begin
                for (int k = 0; k < 3; k++) rb[i][k] = rb[i][k+1];
                rb[i][3] = nb;
            end else begin
                rb[i][mn[i]] = nb;
                mn[i] = mn[i] + 1;
            end
            eq = (mn[i] == 4);
            for (int k = 0; k < 4; k++)
                if (rb[i][k] != bit'((pat[i] >> (3 - k)) & 1)) eq = 1'b0;
            mmatch[i] = eq;
            if (eq && mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
            if (eq && !ovl[i]) mn[i] = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else if (clr) model_clear();
        else if (v) model_accept(b);
        else for (int i = 0; i < 3; i++) mmatch[i] = 1'b0;
    end

    int dm[3];
    int dc[3];
    int df[3];
    always_comb begin
        dm[0] = int'(ia.match);
        dm[1] = int'(ib.match);
        dm[2] = int'(ic.match);
        dc[0] = int'(ia.match_cnt);
        dc[1] = int'(ib.match_cnt);
        dc[2] = int'(ic.match_cnt);
        df[0] = int'(ia.fill);
        df[1] = int'(ib.fill);
        df[2] = int'(ic.fill);
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (dm[i] != int'(mmatch[i]) || dc[i] != mcnt[i] || df[i] != mn[i]) begin
                    bad++;
                    $display("FAIL model[%0d] t=%0t got m=%0d c=%0d f=%0d want m=%0d c=%0d f=%0d",
                             i, $time, dm[i], dc[i], df[i], mmatch[i], mcnt[i], mn[i]);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the bit is taken.
    task automatic send(input bit nb);
        v = 1'b1;
        b = nb;
        @(negedge clk);
        v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    bit s2[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        #1 rst_n = 1'b0;
        #2 started = 1'b1;
        chk("rst_a_cnt", dc[0], 0);
        chk("rst_a_fill", df[0], 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Overlap / non-overlap on the same stream.
        for (int k = 0; k < 7; k++) begin
            send(s2[k]);
            chk($sformatf("ovl_match_b%0d", k + 1), dm[0], (k == 3 || k == 6) ? 1 : 0);
            chk($sformatf("novl_match_b%0d", k + 1), dm[1], (k == 3) ? 1 : 0);
        end
        chk("ovl_cnt", dc[0], 2);
        chk("ovl_fill", df[0], 4);
        chk("novl_cnt", dc[1], 1);
        chk("novl_fill", df[1], 3);
        chk("c_nomatch_cnt", dc[2], 0);

        // Async reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_match", dm[0], 0);
        chk("arst_cnt", dc[0], 0);
        chk("arst_fill", df[0], 0);
        chk("arst_b_cnt", dc[1], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Valid gaps.
        send(1'b1);
        send(1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gap_idle%0d", k), dm[0], 0);
            idle(1);
        end
        send(1'b1);
        chk("gap_b3", dm[0], 0);
        send(1'b1);
        chk("gap_b4", dm[0], 1);
        chk("gap_cnt", dc[0], 1);
        idle(1);
        chk("gap_after", dm[0], 0);

        // Saturation on the 2-bit counter.
        do_clr();
        chk("clr_c_cnt", dc[2], 0);
        for (int k = 1; k <= 7; k++) begin
            send(1'b1);
            chk($sformatf("sat_match%0d", k), dm[2], (k >= 4) ? 1 : 0);
            chk($sformatf("sat_cnt%0d", k), dc[2], (k >= 6) ? 3 : ((k >= 4) ? k - 3 : 0));
        end
        idle(1);

        // clr beats in_valid in the same cycle.
        do_clr();
        send(1'b1);
        send(1'b0);
        send(1'b1);
        chk("pre_clr_fill", df[0], 3);
        clr = 1'b1;
        v = 1'b1;
        b = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        v = 1'b0;
        chk("clr_match", dm[0], 0);
        chk("clr_fill", df[0], 0);
        chk("clr_cnt", dc[0], 0);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        chk("post_clr_b3", dm[0], 0);
        send(1'b1);
        chk("post_clr_b4", dm[0], 1);
        chk("post_clr_cnt", dc[0], 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
